jtframe_romrq_arb: RTL

Arbiter between several `jtframe_romrq` slots and one SDRAM bank port. It picks one pending slot request and registers its SDRAM address toward the bank controller. It then routes the returning two-word burst back to the granted slot through a one-hot `we` strobe. The slots share `din`, `dst` and `din_ok` by broadcast.

---
 rtl/jtframe_romarb_pkg.sv | 13 +
 rtl/jtframe_romarb_pick.sv | 38 +++
 rtl/jtframe_romrq_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/jtframe_romarb_pkg.sv
// Shared types and constants for the romrq-to-SDRAM-bank arbiter.
package jtframe_romarb_pkg;

  localparam int ROMARB_MAXSLOT = 4;
  localparam int GNT_W          = $clog2(ROMARB_MAXSLOT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } romarb_state_t;

endpackage

// File: rtl/jtframe_romarb_pick.sv
// Combinational request picker: first pending request found searching
// cyclically from start; returns one-hot grant, its index and a valid flag.
module jtframe_romarb_pick
  import jtframe_romarb_pkg::*;
#(
  parameter int NSLOT = 2
) (
  input  logic [NSLOT-1:0] req,
  input  logic [GNT_W-1:0] start,
  output logic [NSLOT-1:0] grant,
  output logic [GNT_W-1:0] idx,
  output logic             any
);

  localparam int PW = GNT_W + 1;

  logic [PW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < NSLOT; k++) begin
      // start < NSLOT, so one subtraction is enough to wrap
      pos = {1'b0, start} + PW'(k);
      if (pos >= PW'(NSLOT)) pos = pos - PW'(NSLOT);
      for (int i = 0; i < NSLOT; i++) begin
        if (!any && req[i] && (pos[GNT_W-1:0] == GNT_W'(i))) begin
          any      = 1'b1;
          idx      = GNT_W'(i);
          grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtframe_romrq_arb.sv
// Arbiter from several romrq slots to one SDRAM bank port. Build with
// JTFRAME_ROMARB_RR_EN for round-robin; otherwise the lowest slot wins.
module jtframe_romrq_arb
  import jtframe_romarb_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int NSLOT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSLOT-1:0]        slot_req,
  input  logic [NSLOT*SDRAMW-1:0] slot_addr,
  output logic [NSLOT-1:0]        slot_we,
  output logic [15:0]             slot_din,
  output logic                    slot_dst,
  output logic                    slot_dok,
  output logic                    sdram_req,
  output logic [SDRAMW-1:0]       sdram_addr,
  input  logic                    sdram_ack,
  input  logic                    sdram_dst,
  input  logic                    sdram_rdy,
  input  logic [15:0]             sdram_din,
  output romarb_state_t           state_dbg
);

  // Handshake: sdram_req is held with a stable sdram_addr until the
  // one-cycle sdram_ack; the burst then returns as dst (word 0) and rdy
  // (word 1) pulses, both landing while slot_we is high. Once raised, a
  // request always runs to rdy regardless of slot_req.
  romarb_state_t     state, state_nxt;
  logic [NSLOT-1:0]  gnt_oh, gnt_oh_nxt, slot_we_nxt, pick_oh;
  logic [GNT_W-1:0]  pick_idx, start_idx;
  logic              pick_any, req_nxt;
  logic [SDRAMW-1:0] addr_nxt, pick_addr;

  assign slot_din  = sdram_din;
  assign slot_dst  = sdram_dst;
  assign slot_dok  = sdram_rdy;
  assign state_dbg = state;

  jtframe_romarb_pick #(.NSLOT(NSLOT)) u_pick (
    .req   (slot_req),
    .start (start_idx),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef JTFRAME_ROMARB_RR_EN
  logic [GNT_W-1:0] rr_ptr;

  assign start_idx = rr_ptr;

  // Holds the slot after the last grant, i.e. where the next search begins
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && pick_any) begin
      rr_ptr <= (pick_idx == GNT_W'(NSLOT-1)) ? '0 : pick_idx + 1'b1;
    end
  end
`else
  assign start_idx = '0;
`endif

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (pick_idx == GNT_W'(i)) pick_addr = slot_addr[i*SDRAMW +: SDRAMW];
    end
  end

  always_comb begin
    state_nxt   = state;
    req_nxt     = sdram_req;
    addr_nxt    = sdram_addr;
    slot_we_nxt = slot_we;
    gnt_oh_nxt  = gnt_oh;
    case (state)
      IDLE: begin
        if (pick_any) begin
          addr_nxt   = pick_addr;
          req_nxt    = 1'b1;
          gnt_oh_nxt = pick_oh;
          state_nxt  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_nxt     = 1'b0;
          slot_we_nxt = gnt_oh;
          state_nxt   = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (sdram_rdy) begin
          slot_we_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      slot_we    <= '0;
      gnt_oh     <= '0;
    end else begin
      state      <= state_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
      slot_we    <= slot_we_nxt;
      gnt_oh     <= gnt_oh_nxt;
    end
  end

endmodule
